// File: rtl/flag_branch_unit_pkg.sv
// Shared constants for the flag/branch unit: condition codes, flag bit positions, FSM states.
package flag_branch_unit_pkg;

  localparam logic [2:0] BrNeq  = 3'b000;
  localparam logic [2:0] BrEq   = 3'b001;
  localparam logic [2:0] BrGt   = 3'b010;
  localparam logic [2:0] BrLt   = 3'b011;
  localparam logic [2:0] BrGte  = 3'b100;
  localparam logic [2:0] BrLte  = 3'b101;
  localparam logic [2:0] BrOvfl = 3'b110;
  localparam logic [2:0] BrUnc  = 3'b111;

  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagV = 1;
  localparam int unsigned FlagN = 0;

  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StRedirect = 2'b01,
    StSquash   = 2'b10
  } fbu_state_e;

endpackage

// File: rtl/flag_branch_unit_if.sv
// EX-stage to flag/branch unit bundle; the slave side is the unit itself.
interface flag_branch_unit_if #(
  parameter int unsigned DSIZE = 16,
  parameter int unsigned OFFW  = 9
);
  logic             ex_valid;
  logic             stall;
  logic [2:0]       alu_flag;
  logic             flag_update;
  logic             is_branch;
  logic [2:0]       cond;
  logic [DSIZE-1:0] pc_plus1;
  logic [OFFW-1:0]  offset;
  logic [2:0]       flag;
  logic             br_taken;
  logic [DSIZE-1:0] br_target;
  logic             squash;

  modport master (
    output ex_valid, stall, alu_flag, flag_update, is_branch, cond, pc_plus1, offset,
    input  flag, br_taken, br_target, squash
  );

  modport slave (
    input  ex_valid, stall, alu_flag, flag_update, is_branch, cond, pc_plus1, offset,
    output flag, br_taken, br_target, squash
  );
endinterface

// File: rtl/flag_branch_unit_cond_eval.sv
// Combinational branch-condition evaluation against the {Z,V,N} flag register.
module flag_branch_unit_cond_eval
  import flag_branch_unit_pkg::*;
(
  input  logic [2:0] cond_i,
  input  logic [2:0] flag_i,
  output logic       cond_true_o
);
  logic z, v, n;

  assign z = flag_i[FlagZ];
  assign v = flag_i[FlagV];
  assign n = flag_i[FlagN];

  always_comb begin
    cond_true_o = 1'b0;
    case (cond_i)
      BrNeq:   cond_true_o = ~z;
      BrEq:    cond_true_o = z;
      BrGt:    cond_true_o = ~z & ~n;
      BrLt:    cond_true_o = n;
      BrGte:   cond_true_o = z | ~n;
      BrLte:   cond_true_o = z | n;
      BrOvfl:  cond_true_o = v;
      BrUnc:   cond_true_o = 1'b1;
      default: cond_true_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/flag_branch_unit.sv
// Flag register, conditional branch resolution, registered PC redirect and wrong-path squash.
module flag_branch_unit
  import flag_branch_unit_pkg::*;
#(
  parameter int unsigned DSIZE        = 16,
  parameter int unsigned OFFW         = 9,
  parameter int unsigned SQUASH_DEPTH = 2
) (
  input logic               clk,
  input logic               rst,
  flag_branch_unit_if.slave bus
);
  fbu_state_e       state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [2:0]       flag_q, flag_d;
  logic             br_taken_q, br_taken_d;
  logic [DSIZE-1:0] br_target_q, br_target_d;
  logic             squash_q, squash_d;
  logic             accept;
  logic             cond_true;
  logic [DSIZE-1:0] offset_sext;

  assign accept      = bus.ex_valid & ~bus.stall & ~squash_q;
  assign offset_sext = {{(DSIZE - OFFW){bus.offset[OFFW-1]}}, bus.offset};

  // Evaluated on the registered flags only: a same-cycle flag write is not bypassed.
  flag_branch_unit_cond_eval u_cond_eval (
    .cond_i      (bus.cond),
    .flag_i      (flag_q),
    .cond_true_o (cond_true)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    flag_d      = flag_q;
    br_taken_d  = br_taken_q;
    br_target_d = br_target_q;
    squash_d    = squash_q;

    if (accept && bus.flag_update) begin
      flag_d = bus.alu_flag;
    end

    case (state_q)
      StIdle: begin
        if (accept && bus.is_branch && cond_true) begin
          state_d     = StRedirect;
          br_taken_d  = 1'b1;
          br_target_d = bus.pc_plus1 + offset_sext;
          squash_d    = 1'b1;
          cnt_d       = 3'(SQUASH_DEPTH);
        end
      end
      StRedirect: begin
        if (!bus.stall) begin
          br_taken_d = 1'b0;
          cnt_d      = cnt_q - 3'd1;
          if (cnt_d == 3'd0) begin
            squash_d = 1'b0;
            state_d  = StIdle;
          end else begin
            state_d = StSquash;
          end
        end
      end
      StSquash: begin
        if (!bus.stall) begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_d == 3'd0) begin
            squash_d = 1'b0;
            state_d  = StIdle;
          end
        end
      end
      default: begin
        state_d    = StIdle;
        br_taken_d = 1'b0;
        squash_d   = 1'b0;
        cnt_d      = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      flag_q      <= 3'd0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
      squash_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      flag_q      <= flag_d;
      br_taken_q  <= br_taken_d;
      br_target_q <= br_target_d;
      squash_q    <= squash_d;
    end
  end

  assign bus.flag      = flag_q;
  assign bus.br_taken  = br_taken_q;
  assign bus.br_target = br_target_q;
  assign bus.squash    = squash_q;
endmodule
